// File: rtl/stage_sequencer.sv
// Multi-cycle control FSM for the RISC-V stage datapath: sequences fetch, decode,
// execute, memory and writeback, drives execute controls and counts retirements.
module stage_sequencer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              pc_src,
    input  logic              imem_ack,
    input  logic              dmem_ack,
    output logic              imem_req,
    output logic              ir_we,
    output logic              dmem_req,
    output logic              mem_we,
    output logic              reg_we,
    output logic              mem_to_reg,
    output logic              branch,
    output logic              ALU_src,
    output logic [3:0]        ALU_op,
    output logic              pc_we,
    output logic              pc_taken,
    output logic              illegal,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  instret
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        TRAP      = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_ALU  = 3'd1,
        CLS_LW   = 3'd2,
        CLS_SW   = 3'd3,
        CLS_BEQ  = 3'd4
    } cls_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic             alu_src_q, alu_src_d;
    logic             branch_q, branch_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             imem_req_q, imem_req_d;
    logic             dmem_req_q, dmem_req_d;
    logic             mem_we_q, mem_we_d;
    logic             reg_we_q, reg_we_d;
    logic             mem_to_reg_q, mem_to_reg_d;

    logic             dec_legal;
    cls_t             dec_cls;
    logic [3:0]       dec_op;
    logic             dec_src;
    logic             dec_branch;
    logic [3:0]       f3_op;

    logic             unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // Shared funct3 table for R-type and I-ALU; instr[30] selects SUB/SRA.
    always_comb begin
        f3_op = OP_ADD;
        unique case (instr[14:12])
            3'b000: f3_op = OP_ADD;
            3'b001: f3_op = OP_SLL;
            3'b010: f3_op = OP_SLT;
            3'b011: f3_op = OP_SLTU;
            3'b100: f3_op = OP_XOR;
            3'b101: f3_op = instr[30] ? OP_SRA : OP_SRL;
            3'b110: f3_op = OP_OR;
            3'b111: f3_op = OP_AND;
            default: f3_op = OP_ADD;
        endcase
    end

    always_comb begin
        dec_legal  = 1'b0;
        dec_cls    = CLS_NONE;
        dec_op     = OP_ADD;
        dec_src    = 1'b0;
        dec_branch = 1'b0;
        case (instr[6:0])
            7'b0110011: begin
                dec_legal = 1'b1;
                dec_cls   = CLS_ALU;
                dec_op    = (instr[14:12] == 3'b000 && instr[30]) ? OP_SUB : f3_op;
            end
            7'b0010011: begin
                dec_legal = 1'b1;
                dec_cls   = CLS_ALU;
                dec_src   = 1'b1;
                dec_op    = f3_op;
            end
            7'b0000011: begin
                dec_legal = (instr[14:12] == 3'b010);
                dec_cls   = CLS_LW;
                dec_src   = 1'b1;
            end
            7'b0100011: begin
                dec_legal = (instr[14:12] == 3'b010);
                dec_cls   = CLS_SW;
                dec_src   = 1'b1;
            end
            7'b1100011: begin
                dec_legal  = (instr[14:12] == 3'b000);
                dec_cls    = CLS_BEQ;
                dec_op     = OP_SUB;
                dec_branch = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Ack-qualified strobes are combinational so zero-wait acks cost no extra cycle.
    assign ir_we    = (state_q == FETCH) && imem_ack && !reset;
    assign pc_we    = !reset && (((state_q == EXECUTE) && (cls_q == CLS_BEQ))
                   || ((state_q == MEMORY) && (cls_q == CLS_SW) && dmem_ack)
                   || (state_q == WRITEBACK));
    assign pc_taken = !reset && (state_q == EXECUTE) && (cls_q == CLS_BEQ) && pc_src;

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        alu_op_d  = alu_op_q;
        alu_src_d = alu_src_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;
        instret_d = instret_q + CNT_W'(pc_we);

        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (imem_ack) state_d = DECODE;
            DECODE: begin
                if (dec_legal) begin
                    state_d   = EXECUTE;
                    cls_d     = dec_cls;
                    alu_op_d  = dec_op;
                    alu_src_d = dec_src;
                    branch_d  = dec_branch;
                end else begin
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end
            end
            EXECUTE: begin
                case (cls_q)
                    CLS_BEQ:        state_d = FETCH;
                    CLS_LW, CLS_SW: state_d = MEMORY;
                    default:        state_d = WRITEBACK;
                endcase
            end
            MEMORY: begin
                if (dmem_ack) state_d = (cls_q == CLS_LW) ? WRITEBACK : FETCH;
            end
            WRITEBACK: state_d = FETCH;
            TRAP:      state_d = TRAP;
            default:   state_d = IDLE;
        endcase

        if (state_d == FETCH) begin
            cls_d     = CLS_NONE;
            alu_op_d  = '0;
            alu_src_d = 1'b0;
            branch_d  = 1'b0;
        end

        imem_req_d   = (state_d == FETCH);
        dmem_req_d   = (state_d == MEMORY);
        mem_we_d     = (state_d == MEMORY) && (cls_d == CLS_SW);
        reg_we_d     = (state_d == WRITEBACK);
        mem_to_reg_d = (state_d == WRITEBACK) && (cls_d == CLS_LW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cls_q        <= CLS_NONE;
            alu_op_q     <= '0;
            alu_src_q    <= 1'b0;
            branch_q     <= 1'b0;
            illegal_q    <= 1'b0;
            instret_q    <= '0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            reg_we_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            alu_op_q     <= alu_op_d;
            alu_src_q    <= alu_src_d;
            branch_q     <= branch_d;
            illegal_q    <= illegal_d;
            instret_q    <= instret_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            mem_we_q     <= mem_we_d;
            reg_we_q     <= reg_we_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign dmem_req   = dmem_req_q;
    assign mem_we     = mem_we_q;
    assign reg_we     = reg_we_q;
    assign mem_to_reg = mem_to_reg_q;
    assign branch     = branch_q;
    assign ALU_src    = alu_src_q;
    assign ALU_op     = alu_op_q;
    assign illegal    = illegal_q;
    assign state      = state_q;
    assign instret    = instret_q;

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Multi-cycle control FSM that sequences the RISC-V stage datapath: fetch, decode, execute, memory, writeback.
- Decodes the instruction register and drives the execute stage controls: branch, ALU_src, ALU_op.
- Drives the instruction/data memory request handshakes and the PC/IR/register-file write strobes.
- Counts retired instructions and traps on unsupported encodings.

Parameters:
CNT_W, 32, width of retired-instruction counter instret

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
instr  input  32  instruction register contents; sampled in DECODE
pc_src  input  1  branch-taken from execute stage (branch AND zero)
imem_ack  input  1  instruction memory done; meaningful only while imem_req=1
dmem_ack  input  1  data memory done; meaningful only while dmem_req=1
imem_req  output  1  instruction fetch request
ir_we  output  1  load IR from instruction memory
dmem_req  output  1  data memory request
mem_we  output  1  data memory write (valid with dmem_req)
reg_we  output  1  register file write strobe
mem_to_reg  output  1  writeback source: 1 = memory data, 0 = ALU_result
branch  output  1  to execute stage
ALU_src  output  1  0 = rs2_data, 1 = imm_extended
ALU_op  output  4  ALU operation code
pc_we  output  1  PC update strobe
pc_taken  output  1  with pc_we: 1 = branch target, 0 = PC+4
illegal  output  1  sticky unsupported-instruction flag
state  output  3  current FSM state, debug
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset: synchronous, active-high; takes priority over everything.
  - State goes to IDLE, registered decode fields clear, instret=0, illegal=0.
  - All outputs are 0 during reset and in IDLE.
  - Reset mid-operation abandons any in-flight request; imem_req/dmem_req drop in the cycle after reset is sampled.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, TRAP=6.
- IDLE -> FETCH unconditionally.
- FETCH:
  - imem_req=1, held until imem_ack.
  - In the ack cycle: ir_we=1, go to DECODE.
  - No ack: stay in FETCH. Zero-wait ack (ack in the first FETCH cycle) is legal.
- DECODE: one cycle; decode instr and register ALU_op, ALU_src, branch and the instruction class.
  - R (opcode 0110011): ALU_src=0.
  - I-ALU (0010011): ALU_src=1.
  - LW (0000011, funct3 010): ALU_src=1, ALU_op=ADD.
  - SW (0100011, funct3 010): ALU_src=1, ALU_op=ADD.
  - BEQ (1100011, funct3 000): ALU_src=0, ALU_op=SUB, branch=1.
  - Anything else: go to TRAP. Otherwise go to EXECUTE.
- ALU_op encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- R-type ALU_op from funct3 / instr[30]:
  - 000: ADD if instr[30]=0, SUB if 1.
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 110 OR; 111 AND.
  - 101: SRL if instr[30]=0, SRA if 1.
  - Other funct7 bits are ignored.
- I-ALU: same table, except 000 is always ADD.
- branch, ALU_src and ALU_op are stable from EXECUTE through the instruction's last cycle; they are 0 in FETCH, DECODE and IDLE.
- EXECUTE (one cycle):
  - BEQ: pc_we=1, pc_taken=pc_src, instruction retires, go to FETCH.
  - LW/SW: go to MEMORY.
  - R/I: go to WRITEBACK.
- MEMORY:
  - dmem_req=1; mem_we=1 for SW, 0 for LW; held until dmem_ack.
  - LW ack: go to WRITEBACK.
  - SW ack: pc_we=1 in the ack cycle, instruction retires, go to FETCH.
- WRITEBACK (one cycle): reg_we=1, mem_to_reg=1 for LW else 0, pc_we=1, pc_taken=0, instruction retires, go to FETCH.
- TRAP: illegal=1; all strobes and requests stay 0; stays in TRAP until reset.
- Strobes: pc_we, ir_we and reg_we are single-cycle pulses; pc_taken=0 whenever pc_we=0.
- Acks: imem_ack/dmem_ack are ignored while the corresponding req=0.
- instret: increments by 1 in every cycle pc_we=1; wraps modulo 2^CNT_W from all-ones to 0.
- Instruction latency:
  - BEQ: 3 cycles.
  - R/I: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - These counts assume zero-wait acks; each wait cycle adds 1.

Test Plan:
- Reset, then instr=0x002081B3 (ADD), imem_ack=1 -> state sequence IDLE,FETCH,DECODE,EXECUTE,WRITEBACK; ALU_op=0000, ALU_src=0; reg_we=1 and pc_we=1 in WRITEBACK; instret=1.
- instr=0x402081B3 (SUB), then 0x4020D193 (SRAI) -> ALU_op=0001 ALU_src=0, then ALU_op=0111 ALU_src=1.
- instr=0x0000A183 (LW), dmem_ack delayed 3 cycles -> dmem_req=1 for 4 cycles with mem_we=0; then WRITEBACK with mem_to_reg=1; total 8 cycles.
- instr=0x00208463 (BEQ), pc_src=1 then pc_src=0 -> branch=1, ALU_op=0001; pc_we=1 in EXECUTE with pc_taken=1, then 0; no reg_we; instret +1 each.
- instr=0x0000007F -> TRAP (state=6), illegal=1, no further imem_req; reset -> illegal=0, state=IDLE.
- SW 0x0020A023 with dmem_ack held 0; assert reset in 2nd MEMORY cycle -> dmem_req=0 and state=IDLE the next cycle, instret=0; with CNT_W=4, 16 retirements -> instret wraps to 0.
